// File: rtl/id_branch_predictor_if.sv
// Pipeline <-> branch predictor bundle: IF-stage lookup, ID-stage resolve and statistics.
// master = pipeline side, slave = predictor side.
`timescale 1ns/1ps
interface id_branch_predictor_if #(
    parameter int W = 32
);
    logic [W-1:0]  if_pc;
    logic          if_pred_taken;
    logic [W-1:0]  if_pred_target;
    logic          id_valid;
    logic          id_stall;
    logic [W-1:0]  id_pc;
    logic [2:0]    id_branch_type;
    logic [W-1:0]  id_cmp_a;
    logic [W-1:0]  id_cmp_b;
    logic [15:0]   id_offset;
    logic          id_pred_taken;
    logic [W-1:0]  id_pred_target;
    logic          redirect;
    logic [W-1:0]  redirect_pc;
    logic [31:0]   stat_branches;
    logic [31:0]   stat_mispredicts;

    modport master (
        output if_pc, id_valid, id_stall, id_pc, id_branch_type,
               id_cmp_a, id_cmp_b, id_offset, id_pred_taken, id_pred_target,
        input  if_pred_taken, if_pred_target, redirect, redirect_pc,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, id_valid, id_stall, id_pc, id_branch_type,
               id_cmp_a, id_cmp_b, id_offset, id_pred_taken, id_pred_target,
        output if_pred_taken, if_pred_target, redirect, redirect_pc,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/id_branch_predictor.sv
// Direct-mapped branch target table with 2-bit counters plus ID-stage branch resolution.
// Optional resolve/mispredict statistics counters are built when BPU_STATS_EN is defined.
`timescale 1ns/1ps
module id_branch_predictor #(
    parameter int W        = 32,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    id_branch_predictor_if.slave bpu
);
    localparam int DEPTH = 1 << IDX_BITS;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6,
        BR_RSVD = 3'd7
    } brType_e;

    logic                validTable_r  [DEPTH];
    logic [TAG_BITS-1:0] tagTable_r    [DEPTH];
    logic [W-1:0]        targetTable_r [DEPTH];
    logic [1:0]          ctrTable_r    [DEPTH];

    function automatic logic [1:0] ctrStep(input logic [1:0] ctr, input logic up);
        logic [1:0] nxt;
        if (up) begin
            if (ctr == 2'b11) nxt = ctr;
            else              nxt = ctr + 2'd1;
        end else begin
            if (ctr == 2'b00) nxt = ctr;
            else              nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

    logic [IDX_BITS-1:0] lkIdx_s;
    logic [TAG_BITS-1:0] lkTag_s;
    logic                lkHit_s;
    logic                lkTaken_s;
    logic [W-1:0]        lkSeqPc_s;

    // Fetch-side lookup straight from the registered table; no bypass of a same-cycle update.
    always_comb begin
        lkIdx_s   = bpu.if_pc[IDX_BITS+1:2];
        lkTag_s   = bpu.if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
        lkHit_s   = validTable_r[lkIdx_s] && (tagTable_r[lkIdx_s] == lkTag_s);
        lkTaken_s = lkHit_s && ctrTable_r[lkIdx_s][1];
        lkSeqPc_s = bpu.if_pc + W'(3'd4);
        bpu.if_pred_taken = lkTaken_s;
        if (lkTaken_s) begin
            bpu.if_pred_target = targetTable_r[lkIdx_s];
        end else begin
            bpu.if_pred_target = lkSeqPc_s;
        end
    end

    logic         isBranch_s;
    logic         condTaken_s;
    logic         aNeg_s;
    logic         aZero_s;
    logic         resolve_s;
    logic         mispredict_s;
    logic [W-1:0] offExt_s;
    logic [W-1:0] seqPc_s;
    logic [W-1:0] brTarget_s;

    // ID-stage condition evaluation, target computation and mispredict detection.
    always_comb begin
        aNeg_s      = bpu.id_cmp_a[W-1];
        aZero_s     = (bpu.id_cmp_a == {W{1'b0}});
        isBranch_s  = 1'b0;
        condTaken_s = 1'b0;
        case (brType_e'(bpu.id_branch_type))
            BR_BEQ:  begin isBranch_s = 1'b1; condTaken_s = (bpu.id_cmp_a == bpu.id_cmp_b); end
            BR_BNE:  begin isBranch_s = 1'b1; condTaken_s = (bpu.id_cmp_a != bpu.id_cmp_b); end
            BR_BLEZ: begin isBranch_s = 1'b1; condTaken_s = aNeg_s || aZero_s;           end
            BR_BGTZ: begin isBranch_s = 1'b1; condTaken_s = !aNeg_s && !aZero_s;         end
            BR_BLTZ: begin isBranch_s = 1'b1; condTaken_s = aNeg_s;                      end
            BR_BGEZ: begin isBranch_s = 1'b1; condTaken_s = !aNeg_s;                     end
            default: begin isBranch_s = 1'b0; condTaken_s = 1'b0;                        end
        endcase

        resolve_s  = bpu.id_valid && !bpu.id_stall && isBranch_s;
        offExt_s   = {{(W-16){bpu.id_offset[15]}}, bpu.id_offset};
        seqPc_s    = bpu.id_pc + W'(3'd4);
        brTarget_s = seqPc_s + {offExt_s[W-3:0], 2'b00};

        // A taken prediction to the wrong place is as bad as the wrong direction.
        mispredict_s = resolve_s &&
                       ((condTaken_s != bpu.id_pred_taken) ||
                        (condTaken_s && (bpu.id_pred_target != brTarget_s)));

        bpu.redirect = mispredict_s;
        if (condTaken_s) begin
            bpu.redirect_pc = brTarget_s;
        end else begin
            bpu.redirect_pc = seqPc_s;
        end
    end

    logic [IDX_BITS-1:0] upIdx_s;
    logic [TAG_BITS-1:0] upTag_s;
    logic                upHit_s;

    // Table slot addressed by the resolving branch.
    always_comb begin
        upIdx_s = bpu.id_pc[IDX_BITS+1:2];
        upTag_s = bpu.id_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
        upHit_s = validTable_r[upIdx_s] && (tagTable_r[upIdx_s] == upTag_s);
    end

    // Table training: step counter on hit, allocate weakly-taken on a taken miss.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                validTable_r[i]  <= 1'b0;
                tagTable_r[i]    <= {TAG_BITS{1'b0}};
                targetTable_r[i] <= {W{1'b0}};
                ctrTable_r[i]    <= 2'b01;
            end
        end else if (resolve_s) begin
            if (upHit_s) begin
                ctrTable_r[upIdx_s] <= ctrStep(ctrTable_r[upIdx_s], condTaken_s);
                if (condTaken_s) begin
                    targetTable_r[upIdx_s] <= brTarget_s;
                end
            end else if (condTaken_s) begin
                validTable_r[upIdx_s]  <= 1'b1;
                tagTable_r[upIdx_s]    <= upTag_s;
                targetTable_r[upIdx_s] <= brTarget_s;
                ctrTable_r[upIdx_s]    <= 2'b10;
            end
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] statBranches_r;
    logic [31:0] statMispredicts_r;

    // Saturating resolve and mispredict counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            statBranches_r    <= 32'd0;
            statMispredicts_r <= 32'd0;
        end else begin
            if (resolve_s && (statBranches_r != {32{1'b1}})) begin
                statBranches_r <= statBranches_r + 32'd1;
            end
            if (mispredict_s && (statMispredicts_r != {32{1'b1}})) begin
                statMispredicts_r <= statMispredicts_r + 32'd1;
            end
        end
    end

    assign bpu.stat_branches    = statBranches_r;
    assign bpu.stat_mispredicts = statMispredicts_r;
`else
    assign bpu.stat_branches    = 32'd0;
    assign bpu.stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_id_branch_predictor.sv
// Self-checking bench for id_branch_predictor: directed test-plan steps then random resolves,
// all checked against a table model built from the prediction/update rules.
`timescale 1ns/1ps
module tb_id_branch_predictor;
    localparam int W = 32;

    logic clk;
    logic reset;

    id_branch_predictor_if #(.W(W)) bpu ();

    id_branch_predictor #(.W(W), .IDX_BITS(6), .TAG_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bpu   (bpu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        int unsigned tag;
        logic [31:0] tgt;
        int          ctr;
    } ent_t;

    ent_t        mdl [64];
    int unsigned mBranches;
    int unsigned mMis;
    int          vectors;
    int          miscompares;

    function automatic void mReset();
        for (int i = 0; i < 64; i++) begin
            mdl[i].v = 1'b0; mdl[i].tag = 0; mdl[i].tgt = 32'd0; mdl[i].ctr = 1;
        end
        mBranches = 0;
        mMis      = 0;
    endfunction

    function automatic int idxOf(input logic [31:0] pc);
        int unsigned p = pc;
        return int'((p / 4) % 64);
    endfunction

    function automatic int unsigned tagOf(input logic [31:0] pc);
        int unsigned p = pc;
        return (p / 256) % 256;
    endfunction

    function automatic bit mHit(input logic [31:0] pc);
        return mdl[idxOf(pc)].v && (mdl[idxOf(pc)].tag == tagOf(pc));
    endfunction

    function automatic void mPredict(input logic [31:0] pc, output bit t, output logic [31:0] tg);
        t  = mHit(pc) && (mdl[idxOf(pc)].ctr >= 2);
        tg = t ? mdl[idxOf(pc)].tgt : pc + 32'd4;
    endfunction

    function automatic bit mCond(input int typ, input logic [31:0] a, input logic [31:0] b);
        int sa = a;
        case (typ)
            1: return a == b;
            2: return a != b;
            3: return sa <= 0;
            4: return sa > 0;
            5: return sa < 0;
            6: return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] mTarget(input logic [31:0] pc, input logic [15:0] off);
        shortint s16 = off;
        int      s32 = s16;
        return pc + 32'd4 + 32'(s32 * 4);
    endfunction

    function automatic void mUpdate(input logic [31:0] pc, input bit tk, input logic [31:0] tgt, input bit mis);
        int i = idxOf(pc);
        if (mHit(pc)) begin
            mdl[i].ctr = tk ? ((mdl[i].ctr == 3) ? 3 : mdl[i].ctr + 1)
                            : ((mdl[i].ctr == 0) ? 0 : mdl[i].ctr - 1);
            if (tk) mdl[i].tgt = tgt;
        end else if (tk) begin
            mdl[i].v = 1'b1; mdl[i].tag = tagOf(pc); mdl[i].tgt = tgt; mdl[i].ctr = 2;
        end
        if (mBranches != 32'hFFFFFFFF) mBranches++;
        if (mis && (mMis != 32'hFFFFFFFF)) mMis++;
    endfunction

    function automatic logic [31:0] expBr();
`ifdef BPU_STATS_EN
        return mBranches;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] expMis();
`ifdef BPU_STATS_EN
        return mMis;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One ID cycle: apply inputs, check lookup/resolve/stats, then clock and train the model.
    task automatic drive(input int typ, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] off, input bit pt, input logic [31:0] ptgt,
                         input bit vld, input bit stl, input logic [31:0] lkpc);
        bit          eT, r, tk, mis;
        logic [31:0] eTg, tgt, nxt;
        bpu.if_pc          = lkpc;
        bpu.id_valid       = vld;
        bpu.id_stall       = stl;
        bpu.id_pc          = pc;
        bpu.id_branch_type = 3'(typ);
        bpu.id_cmp_a       = a;
        bpu.id_cmp_b       = b;
        bpu.id_offset      = off;
        bpu.id_pred_taken  = pt;
        bpu.id_pred_target = ptgt;
        #2;
        mPredict(lkpc, eT, eTg);
        check("lookup_taken", {31'd0, bpu.if_pred_taken}, {31'd0, eT});
        check("lookup_target", bpu.if_pred_target, eTg);
        r   = vld && !stl && (typ >= 1) && (typ <= 6);
        tk  = mCond(typ, a, b);
        tgt = mTarget(pc, off);
        nxt = tk ? tgt : pc + 32'd4;
        mis = r && ((tk != pt) || (tk && (ptgt != tgt)));
        check("redirect", {31'd0, bpu.redirect}, {31'd0, mis});
        if (r) check("redirect_pc", bpu.redirect_pc, nxt);
        check("stat_branches", bpu.stat_branches, expBr());
        check("stat_mispredicts", bpu.stat_mispredicts, expMis());
        @(posedge clk);
        if (r) mUpdate(pc, tk, tgt, mis);
        #1;
        bpu.id_valid = 1'b0;
        bpu.id_stall = 1'b0;
    endtask

    task automatic idle(input logic [31:0] lkpc);
        drive(0, 32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0, lkpc);
    endtask

    initial begin
        bit          pt;
        logic [31:0] ptgt, pc, a, b, lk;
        vectors     = 0;
        miscompares = 0;
        mReset();
        reset = 1'b0;
        bpu.if_pc = 32'h00400010; bpu.id_valid = 1'b0; bpu.id_stall = 1'b0;
        bpu.id_pc = 32'd0; bpu.id_branch_type = 3'd0; bpu.id_cmp_a = 32'd0; bpu.id_cmp_b = 32'd0;
        bpu.id_offset = 16'd0; bpu.id_pred_taken = 1'b0; bpu.id_pred_target = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state.
        #2;
        check("rst_pred_taken", {31'd0, bpu.if_pred_taken}, 32'd0);
        check("rst_pred_target", bpu.if_pred_target, 32'h00400014);
        check("rst_redirect", {31'd0, bpu.redirect}, 32'd0);
        check("rst_stat_branches", bpu.stat_branches, 32'd0);
        idle(32'h00400010);

        // beq taken, predicted not taken; lookup during resolve still sees the old table.
        drive(1, 32'h00400020, 32'd5, 32'd5, 16'h0003, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00400020);
        idle(32'h00400020);
        // Not taken three times, then taken once: counter must bottom out at 00.
        mPredict(32'h00400020, pt, ptgt);
        drive(1, 32'h00400020, 32'd5, 32'd6, 16'h0003, pt, ptgt, 1'b1, 1'b0, 32'h00400020);
        for (int k = 0; k < 2; k++) begin
            mPredict(32'h00400020, pt, ptgt);
            drive(1, 32'h00400020, 32'd1, 32'd2, 16'h0003, pt, ptgt, 1'b1, 1'b0, 32'h00400020);
        end
        drive(1, 32'h00400020, 32'd7, 32'd7, 16'h0003, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00400020);
        idle(32'h00400020);

        // Sign-sensitive conditions at their boundaries.
        drive(5, 32'h00400100, 32'h80000000, 32'd0, 16'hFFF0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00400100);
        drive(4, 32'h00400104, 32'h80000000, 32'd0, 16'h0010, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00400100);
        drive(3, 32'h00400108, 32'd0, 32'd0, 16'h0004, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00400108);
        drive(6, 32'h0040010C, 32'd0, 32'd0, 16'h8000, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0040010C);
        drive(4, 32'h00400110, 32'd1, 32'd0, 16'h0001, 1'b1, 32'h00400118, 1'b1, 1'b0, 32'h00400110);

        // Stalled mispredicting bne, then released.
        drive(2, 32'h00400060, 32'd1, 32'd2, 16'h0008, 1'b0, 32'd0, 1'b1, 1'b1, 32'h00400060);
        drive(2, 32'h00400060, 32'd1, 32'd2, 16'h0008, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00400060);
        idle(32'h00400060);

        // Aliasing: same index, different tag.
        drive(1, 32'h00400040, 32'd3, 32'd3, 16'h0001, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00400040);
        drive(1, 32'h00401040, 32'd3, 32'd3, 16'h0002, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00401040);
        idle(32'h00400040);
        idle(32'h00401040);
        drive(7, 32'h00401040, 32'd3, 32'd3, 16'h0002, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00401040);

        // Random resolves over a small, heavily aliased PC pool.
        for (int n = 0; n < 400; n++) begin
            pc = 32'h00400000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
            lk = 32'h00400000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
            case ($urandom_range(0, 3))
                0:       a = 32'd0;
                1:       a = 32'h80000000;
                2:       a = 32'($urandom_range(0, 6)) - 32'd3;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 1) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) != 0) begin
                mPredict(pc, pt, ptgt);
            end else begin
                pt   = 1'($urandom_range(0, 1));
                ptgt = $urandom;
            end
            drive(int'($urandom_range(0, 7)), pc, a, b, 16'($urandom), pt, ptgt,
                  ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0), lk);
        end

        // Asynchronous reset mid-cycle with a pending taken update that must be dropped.
        bpu.if_pc = 32'h00400180; bpu.id_valid = 1'b1; bpu.id_stall = 1'b0;
        bpu.id_pc = 32'h00400180; bpu.id_branch_type = 3'd1;
        bpu.id_cmp_a = 32'd0; bpu.id_cmp_b = 32'd0; bpu.id_offset = 16'h0002;
        bpu.id_pred_taken = 1'b0; bpu.id_pred_target = 32'd0;
        #2;
        reset = 1'b0;
        #1;
        check("arst_stat_branches", bpu.stat_branches, 32'd0);
        check("arst_stat_mispredicts", bpu.stat_mispredicts, 32'd0);
        check("arst_pred_taken", {31'd0, bpu.if_pred_taken}, 32'd0);
        check("arst_pred_target", bpu.if_pred_target, 32'h00400184);
        @(posedge clk);
        #1;
        mReset();
        bpu.id_valid = 1'b0;
        reset = 1'b1;
        idle(32'h00400180);
        idle(32'h00400020);
        drive(1, 32'h00400180, 32'd9, 32'd9, 16'h0002, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00400180);
        idle(32'h00400180);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/id_branch_predictor.md
# id_branch_predictor

Parametrised branch prediction and ID-stage branch resolution unit. It holds a direct-mapped branch target table with 2-bit saturating counters that is looked up by IF every cycle. In ID it evaluates the six branch conditions on forwarded operands, compares the real outcome against the prediction carried down the IF/ID register, and issues a same-cycle redirect on mispredict. Outcomes update the table on the following clock edge.

## Interface
Parameters:
- W, 32, datapath/PC width (≥ IDX_BITS+TAG_BITS+2)
- IDX_BITS, 6, table index bits; DEPTH = 2^IDX_BITS entries
- TAG_BITS, 8, tag bits per entry

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears table and statistics
- if_pc  in  W  fetch PC for lookup
- if_pred_taken  out  1  prediction for if_pc
- if_pred_target  out  W  predicted next PC (if_pc+4 when not taken)
- id_valid  in  1  ID holds a valid instruction
- id_stall  in  1  ID held this cycle (load-use or similar)
- id_pc  in  W  PC of the instruction in ID
- id_branch_type  in  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (treated as none)
- id_cmp_a, id_cmp_b  in  W  forwarded branch operands
- id_offset  in  16  branch immediate (word offset)
- id_pred_taken  in  1  prediction captured at fetch
- id_pred_target  in  W  predicted target captured at fetch
- redirect  out  1  mispredict; IF must load redirect_pc and IF/ID must flush
- redirect_pc  out  W  correct next PC
- stat_branches  out  32  resolved branch count
- stat_mispredicts  out  32  mispredict count

## Operation
- Entry: valid, tag[TAG_BITS], target[W], ctr[2]. idx = pc[IDX_BITS+1:2]; tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- Lookup (combinational from registered table): hit = valid && tag match; if_pred_taken = hit && ctr[1]; if_pred_target = if_pred_taken ? target : if_pc+4.
- Resolve event R = id_valid && !id_stall && id_branch_type in 1..6.
- Conditions: beq a==b; bne a!=b; blez/bgtz/bltz/bgez use signed two's-complement compare of id_cmp_a against 0.
- Branch target = id_pc + 4 + (sign-extended id_offset << 2), modulo 2^W.
- taken as per condition; actual_next = taken ? target : id_pc+4.
- mispredict = R && ((taken != id_pred_taken) || (taken && id_pred_target != target)).
- redirect = mispredict; redirect_pc = actual_next (driven whenever R, don't-care otherwise).
- Update at clock edge when R, index/tag from id_pc:
  - hit: ctr saturating +1 if taken, −1 if not (11 and 00 saturate); if taken, target ← branch target.
  - miss and taken: allocate/overwrite: valid=1, tag, target, ctr=10.
  - miss and not taken: no change.
- id_stall or !id_valid: no update, redirect=0.

## Timing
- Lookup and resolve are zero-latency combinational; table update visible to lookups from the next cycle.
- Same-cycle lookup and update of the same index: lookup returns pre-update contents (no bypass).
- Reset asserted: all valid=0, all ctr=01, stats=0 immediately; a pending update in that cycle is discarded. After reset: if_pred_taken=0, if_pred_target=if_pc+4, redirect=0 while id_valid=0.
- Back-to-back resolves on consecutive cycles each update independently; same entry sees counter step twice.

## Configuration
- BPU_STATS_EN defined: stat_branches increments on every R; stat_mispredicts increments on every mispredict; both saturate at 32'hFFFFFFFF; reset to 0.
- Not defined: counters not built; both stat ports tied to 0.

## Test plan
- Reset then lookup if_pc=0x00400010 -> if_pred_taken=0, if_pred_target=0x00400014; redirect=0.
- beq at id_pc=0x00400020, a=b=5, offset=0x0003, pred not taken -> redirect=1, redirect_pc=0x00400030; next cycle lookup at 0x00400020 -> taken, target 0x00400030, ctr=10.
- Same branch resolved not-taken twice -> ctr 10→01→00; lookup predicts not taken; third not-taken keeps 00, no redirect when predicted not-taken.
- bltz with a=0x80000000 -> taken; bgtz with a=0x80000000 -> not taken; blez a=0 -> taken; bgez a=0 -> taken.
- id_stall=1 with mispredicting bne -> redirect=0, table unchanged; release stall -> redirect=1, update occurs once.
- Alias: two taken branches with same idx, different tag -> second overwrites first; first then misses (predict not taken). With BPU_STATS_EN, 10 resolves / 3 mispredicts -> stat_branches=10, stat_mispredicts=3; async reset mid-run -> both 0.
